// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
//  Shared types and constants for the EX-stage HI/LO controller and the
//  divider handshake it drives.
//  Contents:
//    muldiv_op_t     decoded muldiv operation carried by EX
//    muldiv_state_t  controller FSM states
//    DIV_OP_*        encodings of the div_op request to the divider
//    is_div_op       true for DIV/DIVU
//    is_muldiv_op    true for any real muldiv operation
// ----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } muldiv_state_t;

  localparam logic [1:0] DIV_OP_SIGNED   = 2'b10;
  localparam logic [1:0] DIV_OP_UNSIGNED = 2'b01;
  localparam logic [1:0] DIV_OP_IDLE     = 2'b00;

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Encoding 3'd7 is not a muldiv op and must never stall the pipe.
  function automatic logic is_muldiv_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MTHI)  || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_hilo_ctrl
//  EX-stage owner of the HI/LO registers and requester side of the multi-cycle
//  divider handshake. Multiplies and MTHI/MTLO complete in one cycle; divides
//  issue a single div_op pulse and stall EX until the divider reports done.
//  A flush while a divide is in flight sends the FSM to DRAIN, where the
//  (non-abortable) divider is allowed to finish and its result is discarded.
//  A watchdog bounds the time spent waiting on the divider.
//
// Ports
//  clk             in   1   clock
//  resetn          in   1   synchronous, active-low reset
//  i_op_valid      in   1   EX holds a muldiv op (stable while stalled)
//  i_op            in   3   muldiv_op_t
//  i_rs_data       in   32  dividend / multiplicand / MTHI-MTLO source
//  i_rt_data       in   32  divisor / multiplier
//  i_flush         in   1   squash the EX op
//  i_pipe_stall    in   1   pipe frozen by another source this cycle
//  o_stall_req     out  1   combinational: hold EX, divide not complete
//  o_hi_out        out  32  HI register
//  o_lo_out        out  32  LO register
//  o_div_op        out  2   divider request: 10 signed, 01 unsigned, 00 idle
//  o_div_dividend  out  32  divider dividend (valid in the div_op cycle)
//  o_div_divisor   out  32  divider divisor  (valid in the div_op cycle)
//  i_div_result    in   64  divider result: [63:32] remainder, [31:0] quotient
//  i_div_done      in   1   divider idle / result valid
//  o_div_timeout   out  1   one-cycle pulse on watchdog expiry
// ----------------------------------------------------------------------------
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_CYCLES  = 34,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_op_valid,
  input  muldiv_op_t  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  input  logic        i_flush,
  input  logic        i_pipe_stall,
  output logic        o_stall_req,
  output logic [31:0] o_hi_out,
  output logic [31:0] o_lo_out,
  output logic [1:0]  o_div_op,
  output logic [31:0] o_div_dividend,
  output logic [31:0] o_div_divisor,
  input  logic [63:0] i_div_result,
  input  logic        i_div_done,
  output logic        o_div_timeout
);

  // A healthy divide must never trip the watchdog, so the effective limit is
  // clamped to at least one cycle beyond the divider latency.
  localparam int WD_LIMIT = (DIV_TIMEOUT > DIV_CYCLES) ? DIV_TIMEOUT : (DIV_CYCLES + 1);
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  muldiv_state_t     r_state;
  muldiv_state_t     w_state_next;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  logic [31:0]       w_hi_next;
  logic [31:0]       w_lo_next;
  logic [WD_W-1:0]   r_wdog;
  logic [WD_W-1:0]   w_wdog_next;

  logic              w_stall;
  logic [1:0]        w_div_op;
  logic              w_timeout;
  logic              w_op_live;
  logic              w_wd_expired;
  logic              w_new_op_waits;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;

  // Full 64-bit products from explicitly extended operands.
  assign w_prod_s = $signed({{32{i_rs_data[31]}}, i_rs_data}) *
                    $signed({{32{i_rt_data[31]}}, i_rt_data});
  assign w_prod_u = {32'd0, i_rs_data} * {32'd0, i_rt_data};

  assign w_op_live      = i_op_valid & ~i_flush;
  assign w_wd_expired   = (r_wdog == WD_LAST);
  assign w_new_op_waits = w_op_live & is_muldiv_op(i_op);

  // --------------------------------------------------------------------------
  // State, HI/LO and watchdog registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_wdog  <= w_wdog_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, HI/LO writes and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_wdog_next  = '0;
    w_stall      = 1'b0;
    w_div_op     = DIV_OP_IDLE;
    w_timeout    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_op_live) begin
          case (i_op)
            OP_DIV, OP_DIVU: begin
              // The op stays in EX either way; it only issues once the
              // divider is idle (it may still be busy after a timeout).
              w_stall = 1'b1;
              if (i_div_done) begin
                w_div_op     = (i_op == OP_DIV) ? DIV_OP_SIGNED : DIV_OP_UNSIGNED;
                w_state_next = ST_BUSY;
              end
            end
            OP_MULT: begin
              w_hi_next = w_prod_s[63:32];
              w_lo_next = w_prod_s[31:0];
            end
            OP_MULTU: begin
              w_hi_next = w_prod_u[63:32];
              w_lo_next = w_prod_u[31:0];
            end
            OP_MTHI: w_hi_next = i_rs_data;
            OP_MTLO: w_lo_next = i_rs_data;
            default: ;
          endcase
        end
      end

      ST_BUSY: begin
        if (i_div_done) begin
          // A flush arriving with done discards the result outright.
          w_state_next = ST_IDLE;
          if (!i_flush) begin
            w_hi_next = i_div_result[63:32];
            w_lo_next = i_div_result[31:0];
            // If EX is frozen the divide op is still sitting there; HOLD
            // keeps it from being issued a second time.
            if (i_pipe_stall) begin
              w_state_next = ST_HOLD;
            end
          end
        end else if (w_wd_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end else if (i_flush) begin
          w_wdog_next  = r_wdog + WD_W'(1);
          w_state_next = ST_DRAIN;
        end else begin
          w_wdog_next = r_wdog + WD_W'(1);
          w_stall     = 1'b1;
        end
      end

      ST_HOLD: begin
        if (!i_pipe_stall || i_flush) begin
          w_state_next = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // Any younger muldiv op must wait until the divider is free again;
        // it issues (or executes) from IDLE on the following cycle.
        w_stall = w_new_op_waits;
        if (i_div_done) begin
          w_state_next = ST_IDLE;
        end else if (w_wd_expired) begin
          w_timeout    = 1'b1;
          w_stall      = 1'b0;
          w_state_next = ST_IDLE;
        end else begin
          w_wdog_next = r_wdog + WD_W'(1);
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // Reset is synchronous, so the combinational handshake outputs are
  // gated while resetn is low to keep them quiet during the reset cycle.
  assign o_stall_req    = resetn & w_stall;
  assign o_div_op       = resetn ? w_div_op : DIV_OP_IDLE;
  assign o_div_timeout  = resetn & w_timeout;
  assign o_div_dividend = i_rs_data;
  assign o_div_divisor  = i_rt_data;
  assign o_hi_out       = r_hi;
  assign o_lo_out       = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        pipe_stall;
  logic        stall_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [1:0]  div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [63:0] div_result;
  logic        div_done;
  logic        div_timeout;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.DIV_CYCLES(34), .DIV_TIMEOUT(40)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_op_valid     (op_valid),
    .i_op           (op),
    .i_rs_data      (rs_data),
    .i_rt_data      (rt_data),
    .i_flush        (flush),
    .i_pipe_stall   (pipe_stall),
    .o_stall_req    (stall_req),
    .o_hi_out       (hi_out),
    .o_lo_out       (lo_out),
    .o_div_op       (div_op),
    .o_div_dividend (div_dividend),
    .o_div_divisor  (div_divisor),
    .i_div_result   (div_result),
    .i_div_done     (div_done),
    .o_div_timeout  (div_timeout)
  );

  // Behavioural divider: done drops the cycle after a request and rises
  // 34 cycles after that; m_mute freezes it to exercise the watchdog.
  int          cyc = 0;
  int          m_cnt = 0;
  int          n_issue = 0;
  int          n_back2back = 0;
  logic [1:0]  m_prev_op = 2'b00;
  bit          m_mute = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    m_prev_op <= div_op;
    if (div_op != 2'b00) n_issue <= n_issue + 1;
    if (div_op != 2'b00 && m_prev_op != 2'b00) n_back2back <= n_back2back + 1;
    if (!resetn) begin
      m_cnt      <= 0;
      div_done   <= 1'b1;
      div_result <= '0;
    end else if (div_op != 2'b00) begin
      m_cnt    <= 34;
      div_done <= 1'b0;
      if (div_op == 2'b10)
        div_result <= {$signed(div_dividend) % $signed(div_divisor),
                       $signed(div_dividend) / $signed(div_divisor)};
      else
        div_result <= {div_dividend % div_divisor, div_dividend / div_divisor};
    end else if (m_cnt != 0 && !m_mute) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) div_done <= 1'b1;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected HI/LO pair and compares it with the registers.
  task automatic check_hilo();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_hi"}, 64'(hi_out), 64'(e.hi));
      check({e.tag, "_lo"}, 64'(lo_out), 64'(e.lo));
      $display("txn %s: hi=%h lo=%h", e.tag, hi_out, lo_out);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    op       = o;
    rs_data  = a;
    rt_data  = b;
  endtask

  // Single-cycle op (MULT/MULTU/MTHI/MTLO): no stall, no request, HI/LO next cycle.
  task automatic run_single(input string tag, input muldiv_op_t o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    adv();
    drive(1'b1, o, a, b);
    sb_q.push_back('{tag, eh, el});
    @(negedge clk);
    check({tag, "_stall"}, 64'(stall_req), 64'd0);
    check({tag, "_divop"}, 64'(div_op), 64'd0);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);
    check_hilo();
  endtask

  // Full divide from IDLE: one request, 35 stall cycles, then HI/LO.
  task automatic run_div(input string tag, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] code,
                         input logic [31:0] eh, input logic [31:0] el);
    int stalls;
    int issues0;
    bit done_seen;
    adv();
    drive(1'b1, o, a, b);
    sb_q.push_back('{tag, eh, el});
    @(negedge clk);
    check({tag, "_divop"}, 64'(div_op), 64'(code));
    check({tag, "_dividend"}, 64'(div_dividend), 64'(a));
    check({tag, "_divisor"}, 64'(div_divisor), 64'(b));
    issues0   = n_issue;
    stalls    = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!stall_req) begin
        done_seen = 1'b1;
        break;
      end
      stalls++;
      adv();
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'd35);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);
    check({tag, "_issue_count"}, 64'(n_issue - issues0), 64'd1);
    check_hilo();
  endtask

  initial begin
    int t0;
    int t1;
    int issues0;
    bit seen;

    // ---------------- reset, with a divide presented on the inputs ----------
    resetn     = 1'b0;
    flush      = 1'b0;
    pipe_stall = 1'b0;
    drive(1'b1, OP_DIV, 32'd5, 32'd1);
    adv();
    adv();
    @(negedge clk);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);
    check("reset_divop", 64'(div_op), 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    check("reset_timeout", 64'(div_timeout), 64'd0);
    adv();
    resetn = 1'b1;
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);

    // ---------------- multiplies and moves ----------------------------------
    run_single("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_single("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_single("mult_pos", OP_MULT, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000);
    run_single("mthi",  OP_MTHI,  32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000);
    run_single("mtlo",  OP_MTLO,  32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0);

    // Flushed MULT and MTHI leave HI/LO alone.
    adv();
    drive(1'b1, OP_MULT, 32'd7, 32'd7);
    flush = 1'b1;
    adv();
    drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    adv();
    flush = 1'b0;
    drive(1'b0, OP_NONE, '0, '0);
    sb_q.push_back('{"flushed_writes", 32'h1234_5678, 32'h9ABC_DEF0});
    @(negedge clk);
    check_hilo();

    // MTLO held under pipe_stall re-executes idempotently.
    adv();
    drive(1'b1, OP_MTLO, 32'h0BAD_F00D, 32'd0);
    pipe_stall = 1'b1;
    adv();
    adv();
    pipe_stall = 1'b0;
    @(negedge clk);
    check("mtlo_held_stall", 64'(stall_req), 64'd0);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    sb_q.push_back('{"mtlo_held", 32'h1234_5678, 32'h0BAD_F00D});
    @(negedge clk);
    check_hilo();

    // ---------------- basic divides -----------------------------------------
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 2'b01, 32'd2, 32'd14);
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // ---------------- flush 10 cycles into a DIV, then DIVU 9/3 -------------
    adv();
    drive(1'b1, OP_DIV, 32'd1000, 32'd10);
    @(negedge clk);
    check("flushdiv_divop", 64'(div_op), 64'b10);
    t0      = cyc;
    issues0 = n_issue;
    for (int k = 0; k < 9; k++) adv();
    adv();
    flush = 1'b1;
    @(negedge clk);
    adv();
    flush = 1'b0;
    drive(1'b1, OP_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    check("drain_stall", 64'(stall_req), 64'd1);
    seen = 1'b0;
    t1   = 0;
    for (int k = 0; k < 100; k++) begin
      if (div_op != 2'b00) begin
        seen = 1'b1;
        t1   = cyc;
        break;
      end
      adv();
      @(negedge clk);
    end
    check("drain_reissue_seen", 64'(seen), 64'd1);
    check("drain_reissue_code", 64'(div_op), 64'b01);
    check("drain_reissue_delay", 64'(t1 - t0), 64'd36);
    check("drain_hi_untouched", 64'(hi_out), 64'hFFFF_FFFF);
    check("drain_lo_untouched", 64'(lo_out), 64'hFFFF_FFFD);
    sb_q.push_back('{"divu_9_3", 32'd0, 32'd3});
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      adv();
      @(negedge clk);
      if (!stall_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("divu_9_3_done_seen", 64'(seen), 64'd1);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);
    check("flush_issue_count", 64'(n_issue - issues0), 64'd2);
    check_hilo();

    // ---------------- done while pipe_stall is high for 3 cycles ------------
    adv();
    drive(1'b1, OP_DIVU, 32'd50, 32'd5);
    @(negedge clk);
    check("hold_divop", 64'(div_op), 64'b01);
    issues0 = n_issue;
    sb_q.push_back('{"hold_divu_50_5", 32'd0, 32'd10});
    for (int k = 0; k < 34; k++) adv();
    adv();
    pipe_stall = 1'b1;
    @(negedge clk);
    check("hold_done_stall", 64'(stall_req), 64'd0);
    adv();
    @(negedge clk);
    check("hold1_stall", 64'(stall_req), 64'd0);
    check("hold1_divop", 64'(div_op), 64'd0);
    check_hilo();
    adv();
    @(negedge clk);
    check("hold2_stall", 64'(stall_req), 64'd0);
    check("hold2_divop", 64'(div_op), 64'd0);
    adv();
    pipe_stall = 1'b0;
    @(negedge clk);
    check("hold3_stall", 64'(stall_req), 64'd0);
    check("hold3_divop", 64'(div_op), 64'd0);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);
    check("hold_issue_count", 64'(n_issue - issues0), 64'd1);
    check("hold_lo_once", 64'(lo_out), 64'd10);

    // ---------------- reset in the middle of a divide -----------------------
    adv();
    drive(1'b1, OP_DIV, 32'd20, 32'd3);
    for (int k = 0; k < 5; k++) adv();
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_divop", 64'(div_op), 64'd0);
    check("rst_mid_stall", 64'(stall_req), 64'd0);
    adv();
    @(negedge clk);
    check("rst_mid_hi", 64'(hi_out), 64'd0);
    check("rst_mid_lo", 64'(lo_out), 64'd0);
    adv();
    resetn = 1'b1;
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);

    // ---------------- watchdog with a divider that never answers ------------
    m_mute = 1'b1;
    adv();
    drive(1'b1, OP_DIVU, 32'd7, 32'd1);
    @(negedge clk);
    check("wd_divop", 64'(div_op), 64'b01);
    t0   = cyc;
    t1   = 0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      adv();
      @(negedge clk);
      if (div_timeout) begin
        seen = 1'b1;
        t1   = cyc;
        break;
      end
    end
    check("wd_seen", 64'(seen), 64'd1);
    check("wd_delay", 64'(t1 - t0), 64'd40);
    check("wd_stall", 64'(stall_req), 64'd0);
    adv();
    drive(1'b0, OP_NONE, '0, '0);
    @(negedge clk);
    check("wd_pulse_width", 64'(div_timeout), 64'd0);
    sb_q.push_back('{"wd_no_write", 32'd0, 32'd0});
    check_hilo();
    m_mute = 1'b0;
    resetn = 1'b0;
    adv();
    resetn = 1'b1;
    @(negedge clk);

    // ---------------- global properties -------------------------------------
    check("no_back_to_back_divop", 64'(n_back2back), 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
